// File: rtl/a429_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | a429_pkg: shared ARINC429 word transmitter types and constants        |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package a429_pkg;

    localparam int c_WORD_W  = 32;
    localparam int c_RATE_HI = 100000;
    localparam int c_RATE_LO = 12500;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_DRIVE = 3'd2,
        ST_NULLH = 3'd3,
        ST_GAP   = 3'd4
    } a429_state_t;

    // Bit i of the result is the i-th bit put on the line (label MSB first).
    function automatic logic [c_WORD_W-1:0] a429_tx_order(
        input logic [7:0]  label,
        input logic [15:0] data,
        input logic        parity_en
    );
        logic [c_WORD_W-1:0] w;
        w = '0;
        for (int i = 0; i < 8; i++) begin
            w[i] = label[7-i];
        end
        w[25:10] = data;
        w[31]    = parity_en ? ~(^w[30:0]) : 1'b0;
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/a429_baud_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | a429_baud_gen: half-bit tick generator for the latched line rate      |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module a429_baud_gen
    import a429_pkg::*;
#(
    parameter int CLK_HZ = 50000000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_rate_hi,
    output logic o_tick
);

    localparam int c_HALF_HI = CLK_HZ / (2 * c_RATE_HI);
    localparam int c_HALF_LO = CLK_HZ / (2 * c_RATE_LO);
    localparam int c_CNT_W   = $clog2(c_HALF_LO + 1);

    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_last;

    assign w_last = i_rate_hi ? c_CNT_W'(c_HALF_HI - 1) : c_CNT_W'(c_HALF_LO - 1);
    assign o_tick = i_en && (r_cnt == w_last);

    // Counter is held at zero while disabled so the first half starts aligned.
    always_ff @(posedge clk) begin
        if (rst || !i_en || o_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/a429_tx_word.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | a429_tx_word: ARINC429 single-word RZ transmitter with NULL gap       |
// | Option: define A429_PARITY_EN for odd parity in bit 32.               |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module a429_tx_word
    import a429_pkg::*;
#(
    parameter int CLK_HZ   = 50000000,
    parameter int GAP_BITS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       send_rate,
    input  logic [3:0] dat0,
    input  logic [3:0] dat1,
    input  logic [3:0] dat2,
    input  logic [3:0] dat3,
    input  logic [3:0] dat4,
    input  logic [3:0] dat5,
    output logic       tx_hi,
    output logic       tx_lo,
    output logic       busy,
    output logic       done
);

    localparam int c_CNT_MAX = (2 * GAP_BITS > c_WORD_W) ? 2 * GAP_BITS : c_WORD_W;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
    localparam logic [c_CNT_W-1:0] c_BITS_END = c_CNT_W'(c_WORD_W);
    localparam logic [c_CNT_W-1:0] c_GAP_END  = c_CNT_W'(2 * GAP_BITS - 1);

    a429_state_t         r_state;
    logic [c_WORD_W-1:0] r_shift;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                r_rate;
    logic                r_tx_hi;
    logic                r_tx_lo;
    logic                r_busy;
    logic                r_done;

    logic [c_WORD_W-1:0] w_word;
    logic                w_tick;
    logic                w_baud_en;

`ifdef A429_PARITY_EN
    assign w_word = a429_tx_order({dat1, dat0}, {dat5, dat4, dat3, dat2}, 1'b1);
`else
    assign w_word = a429_tx_order({dat1, dat0}, {dat5, dat4, dat3, dat2}, 1'b0);
`endif

    assign w_baud_en = (r_state == ST_DRIVE) || (r_state == ST_NULLH) || (r_state == ST_GAP);

    a429_baud_gen #(
        .CLK_HZ (CLK_HZ)
    ) u_baud (
        .clk       (clk),
        .rst       (rst),
        .i_en      (w_baud_en),
        .i_rate_hi (r_rate),
        .o_tick    (w_tick)
    );

    // r_cnt counts transmitted bits during the word, then half-bits of the gap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_shift <= '0;
            r_cnt   <= '0;
            r_rate  <= 1'b0;
            r_tx_hi <= 1'b0;
            r_tx_lo <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_busy  <= 1'b1;
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_shift <= w_word;
                    r_rate  <= send_rate;
                    r_cnt   <= '0;
                    r_tx_hi <= w_word[0];
                    r_tx_lo <= ~w_word[0];
                    r_state <= ST_DRIVE;
                end
                ST_DRIVE: begin
                    if (w_tick) begin
                        r_tx_hi <= 1'b0;
                        r_tx_lo <= 1'b0;
                        r_shift <= r_shift >> 1;
                        r_cnt   <= r_cnt + 1'b1;
                        r_state <= ST_NULLH;
                    end
                end
                ST_NULLH: begin
                    if (w_tick) begin
                        if (r_cnt == c_BITS_END) begin
                            r_cnt   <= '0;
                            r_state <= ST_GAP;
                        end else begin
                            r_tx_hi <= r_shift[0];
                            r_tx_lo <= ~r_shift[0];
                            r_state <= ST_DRIVE;
                        end
                    end
                end
                ST_GAP: begin
                    if (w_tick) begin
                        if (r_cnt == c_GAP_END) begin
                            r_cnt   <= '0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= ST_IDLE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_tx_hi <= 1'b0;
                    r_tx_lo <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx_hi = r_tx_hi;
    assign tx_lo = r_tx_lo;
    assign busy  = r_busy;
    assign done  = r_done;

endmodule
`default_nettype wire
